// File: rtl/axi4_slave_ram_if.sv
// AXI4-MM bus bundle between one master and one slave; no logic, wiring only.
// Ignored sideband fields (lock/cache/qos/prot/size) are carried so any AXI4 master port can connect.
interface axi4_slave_ram_if #(
  parameter int DW = 512,
  parameter int AW = 64,
  parameter int IW = 4
);
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [IW-1:0]   awid;
  logic            awlock;
  logic [3:0]      awcache;
  logic [3:0]      awqos;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [1:0]      bresp;
  logic [IW-1:0]   bid;
  logic            bvalid;
  logic            bready;

  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [IW-1:0]   arid;
  logic            arlock;
  logic [3:0]      arcache;
  logic [3:0]      arqos;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic [IW-1:0]   rid;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awlock, awcache, awqos, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arid, arlock, arcache, arqos, arprot, arvalid,
    output arready,
    output rdata, rresp, rid, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awlock, awcache, awqos, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arid, arlock, arcache, arqos, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rid, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_slave_ram.sv
// AXI4 slave RAM, independent write/read FSMs with one transaction each; B 1 cycle after WLAST, R 2 cycles/beat.
// Backpressure: B and R outputs held until BREADY/RREADY; AW/AR not accepted until the channel returns to idle.
module axi4_slave_ram #(
  parameter int DW    = 512,
  parameter int AW    = 64,
  parameter int IW    = 4,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            resetn,
  axi4_slave_ram_if.slave s_axi
);
  localparam int BPW  = DW / 8;
  localparam int OFS  = $clog2(BPW);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [AW-1:0] LIMIT  = AW'(DEPTH * BPW);
  localparam logic [AW-1:0] STRIDE = AW'(BPW);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    burst;
    logic [IW-1:0] id;
  } ctx_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // INCR and WRAP both step by one word; FIXED and the reserved encoding hold.
  function automatic logic [AW-1:0] next_addr(input ctx_t c);
    return (c.burst[0] ^ c.burst[1]) ? c.addr + STRIDE : c.addr;
  endfunction

  logic [DW-1:0] mem [DEPTH];

  // ---------------- write channel ----------------
  w_state_t        w_state, w_state_nx;
  ctx_t            w_ctx;
  logic            w_err;
  logic            aw_rdy, w_rdy, b_vld;
  logic            aw_hs, w_hs;
  logic            w_in_range;
  logic [IDXW-1:0] w_idx;
  logic [DW-1:0]   wmask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    b_vld      = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_rdy = 1'b1;
        if (s_axi.awvalid) w_state_nx = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (s_axi.wvalid && s_axi.wlast) w_state_nx = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (s_axi.bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Readies are masked by reset so nothing looks acceptable while resetn is low.
  assign s_axi.awready = aw_rdy & resetn;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bresp   = (b_vld && w_err) ? 2'b10 : 2'b00;
  assign s_axi.bid     = w_ctx.id;

  assign aw_hs      = s_axi.awvalid & s_axi.awready;
  assign w_hs       = s_axi.wvalid & w_rdy;
  assign w_in_range = w_ctx.addr < LIMIT;
  assign w_idx      = w_ctx.addr[OFS +: IDXW];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_ctx <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_ctx <= '{addr: s_axi.awaddr, burst: s_axi.awburst, id: s_axi.awid};
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_ctx.addr <= next_addr(w_ctx);
      if (!w_in_range) w_err <= 1'b1;
    end
  end

  always_comb begin
    wmask = '0;
    for (int i = 0; i < BPW; i++) wmask[8*i +: 8] = {8{s_axi.wstrb[i]}};
  end

  // ---------------- read channel ----------------
  r_state_t        r_state, r_state_nx;
  ctx_t            r_ctx;
  logic [7:0]      beats_left;
  logic            ar_rdy, r_vld;
  logic            ar_hs, r_hs;
  logic            r_in_range;
  logic [IDXW-1:0] r_idx;
  logic [DW-1:0]   rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    ar_rdy     = 1'b0;
    r_vld      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (s_axi.arvalid) r_state_nx = R_FETCH;
      end
      R_FETCH: r_state_nx = R_DATA;
      R_DATA: begin
        r_vld = 1'b1;
        if (s_axi.rready) r_state_nx = (beats_left == 8'd0) ? R_IDLE : R_FETCH;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  assign s_axi.arready = ar_rdy & resetn;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = (r_vld && !r_in_range) ? 2'b10 : 2'b00;
  assign s_axi.rlast   = r_vld && (beats_left == 8'd0);
  assign s_axi.rid     = r_ctx.id;

  assign ar_hs      = s_axi.arvalid & s_axi.arready;
  assign r_hs       = r_vld & s_axi.rready;
  assign r_in_range = r_ctx.addr < LIMIT;
  assign r_idx      = r_ctx.addr[OFS +: IDXW];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctx      <= '0;
      beats_left <= 8'd0;
    end else if (ar_hs) begin
      r_ctx      <= '{addr: s_axi.araddr, burst: s_axi.arburst, id: s_axi.arid};
      beats_left <= s_axi.arlen;
    end else if (r_hs && beats_left != 8'd0) begin
      r_ctx.addr <= next_addr(r_ctx);
      beats_left <= beats_left - 8'd1;
    end
  end

  // RAM has no reset; a fetch in the same cycle as a write to that word sees the old contents.
  always_ff @(posedge clk) begin
    if (w_hs && w_in_range) mem[w_idx] <= (mem[w_idx] & ~wmask) | (s_axi.wdata & wmask);
    if (r_state == R_FETCH) rdata_q <= r_in_range ? mem[r_idx] : '0;
  end

  // AWLEN does not terminate the burst (WLAST does); the rest are accepted and ignored.
  logic unused_ok;
  assign unused_ok = ^{s_axi.awlen, s_axi.awsize, s_axi.awlock, s_axi.awcache, s_axi.awqos,
                       s_axi.awprot, s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arqos,
                       s_axi.arprot};
endmodule

// File: tb/tb_axi4_slave_ram.sv
// Bench for axi4_slave_ram: table of write/read bursts checked against a word model via B/R scoreboards,
// plus hand sequences for reset state, early W beats and reset in the middle of concurrent bursts.
module tb_axi4_slave_ram;
  localparam int DW = 512, AW = 64, IW = 4, DEPTH = 64;
  localparam int BPW = DW / 8;
  localparam int OFS = $clog2(BPW);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [AW-1:0] LIMIT = AW'(DEPTH * BPW);
  localparam logic [BPW-1:0] ALL = '1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi4_slave_ram_if #(.DW(DW), .AW(AW), .IW(IW)) s_axi();
  axi4_slave_ram #(.DW(DW), .AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .s_axi(s_axi)
  );

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [1:0]     burst;
    logic [IW-1:0]  id;
    logic [63:0]    base;
    bit             ones;
    logic [BPW-1:0] strb;
    logic [1:0]     exp_bresp;
    int             delay;    // write: BREADY delay; read: RREADY stall on first beat
  } vec_t;
  typedef struct {logic [DW-1:0] data; logic [1:0] resp; logic last; logic [IW-1:0] id;} rexp_t;
  typedef struct {logic [1:0] resp; logic [IW-1:0] id;} bexp_t;

  logic [DW-1:0] model [DEPTH];
  rexp_t rq[$];
  bexp_t bq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake within 50 cycles, required one", name);
  endtask

  function automatic logic [AW-1:0] step(input logic [AW-1:0] a, input logic [1:0] burst);
    return (burst == 2'b01 || burst == 2'b10) ? a + AW'(BPW) : a;
  endfunction

  function automatic logic [DW-1:0] beat_data(input vec_t v, input int k);
    return v.ones ? {DW{1'b1}} : DW'(v.base + 64'(k));
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BPW-1:0] strb);
    if (a < LIMIT)
      for (int i = 0; i < BPW; i++)
        if (strb[i]) model[a[OFS +: IDXW]][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic idle_inputs();
    s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = 3'd6; s_axi.awburst = 2'b01; s_axi.awid = '0;
    s_axi.awlock = 1'b0; s_axi.awcache = '0; s_axi.awqos = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = 3'd6; s_axi.arburst = 2'b01; s_axi.arid = '0;
    s_axi.arlock = 1'b0; s_axi.arcache = '0; s_axi.arqos = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;
  endtask

  task automatic do_write(input vec_t v);
    logic [AW-1:0] a;
    bexp_t e;
    int n;
    a = v.addr;
    @(negedge clk);
    s_axi.awaddr = v.addr; s_axi.awlen = v.len; s_axi.awburst = v.burst; s_axi.awid = v.id;
    s_axi.awvalid = 1'b1;
    n = 0;
    while (!s_axi.awready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi.awready) timeout_fail("aw_handshake");
    @(posedge clk); #1 s_axi.awvalid = 1'b0;
    for (int k = 0; k <= int'(v.len); k++) begin
      @(negedge clk);
      s_axi.wdata = beat_data(v, k); s_axi.wstrb = v.strb;
      s_axi.wlast = (k == int'(v.len)); s_axi.wvalid = 1'b1;
      n = 0;
      while (!s_axi.wready && n < 50) begin @(negedge clk); n++; end
      if (!s_axi.wready) timeout_fail("w_handshake");
      @(posedge clk);
      model_write(a, beat_data(v, k), v.strb);
      a = step(a, v.burst);
      #1 s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    end
    bq.push_back('{resp: v.exp_bresp, id: v.id});
    @(negedge clk);
    check("bvalid_latency", DW'(s_axi.bvalid), DW'(1'b1));
    for (int d = 0; d < v.delay; d++) begin
      check("bvalid_held", DW'(s_axi.bvalid), DW'(1'b1));
      check("awready_during_b", DW'(s_axi.awready), DW'(1'b0));
      @(negedge clk);
    end
    s_axi.bready = 1'b1;
    n = 0;
    while (!s_axi.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!s_axi.bvalid) timeout_fail("b_handshake");
    if (bq.size() == 0) timeout_fail("b_scoreboard_empty");
    else begin
      e = bq.pop_front();
      check("bresp", DW'(s_axi.bresp), DW'(e.resp));
      check("bid", DW'(s_axi.bid), DW'(e.id));
    end
    @(posedge clk); #1 s_axi.bready = 1'b0;
    @(negedge clk);
    check("bvalid_once", DW'(s_axi.bvalid), DW'(1'b0));
  endtask

  task automatic do_read(input vec_t v);
    logic [AW-1:0] a;
    rexp_t e;
    int n;
    a = v.addr;
    for (int k = 0; k <= int'(v.len); k++) begin
      e.data = (a < LIMIT) ? model[a[OFS +: IDXW]] : '0;
      e.resp = (a < LIMIT) ? 2'b00 : 2'b10;
      e.last = (k == int'(v.len));
      e.id   = v.id;
      rq.push_back(e);
      a = step(a, v.burst);
    end
    @(negedge clk);
    s_axi.araddr = v.addr; s_axi.arlen = v.len; s_axi.arburst = v.burst; s_axi.arid = v.id;
    s_axi.arvalid = 1'b1;
    n = 0;
    while (!s_axi.arready && n < 50) begin @(negedge clk); n++; end
    if (!s_axi.arready) timeout_fail("ar_handshake");
    @(posedge clk); #1 s_axi.arvalid = 1'b0;
    for (int k = 0; k <= int'(v.len); k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!s_axi.rvalid && n < 50);
      if (!s_axi.rvalid) timeout_fail("r_handshake");
      if (k == 0) check("rvalid_latency", DW'(n), DW'(2));
      if (rq.size() == 0) timeout_fail("r_scoreboard_empty");
      else begin
        e = rq.pop_front();
        check("rdata", s_axi.rdata, e.data);
        check("rresp", DW'(s_axi.rresp), DW'(e.resp));
        check("rlast", DW'(s_axi.rlast), DW'(e.last));
        check("rid", DW'(s_axi.rid), DW'(e.id));
        if (k == 0)
          for (int s = 0; s < v.delay; s++) begin
            @(negedge clk);
            check("rvalid_stall", DW'(s_axi.rvalid), DW'(1'b1));
            check("rdata_stall", s_axi.rdata, e.data);
            check("rlast_stall", DW'(s_axi.rlast), DW'(e.last));
          end
      end
      s_axi.rready = 1'b1;
      @(posedge clk); #1 s_axi.rready = 1'b0;
    end
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    //          wr    addr        len   burst  id     base      ones  strb         bresp  delay
    vecs[0]  = '{1'b1, 64'h0,     8'd3, 2'b01, 4'd5,  64'h1,    1'b0, ALL,         2'b00, 0};
    vecs[1]  = '{1'b0, 64'h0,     8'd3, 2'b01, 4'd5,  64'h0,    1'b0, ALL,         2'b00, 5};
    vecs[2]  = '{1'b1, 64'd128,   8'd0, 2'b01, 4'd1,  64'h0,    1'b1, ALL,         2'b00, 3};
    vecs[3]  = '{1'b1, 64'd128,   8'd0, 2'b01, 4'd2,  64'h0,    1'b0, BPW'(1),     2'b00, 0};
    vecs[4]  = '{1'b0, 64'd128,   8'd0, 2'b01, 4'd3,  64'h0,    1'b0, ALL,         2'b00, 0};
    vecs[5]  = '{1'b1, 64'h40,    8'd2, 2'b00, 4'd6,  64'hA,    1'b0, ALL,         2'b00, 0};
    vecs[6]  = '{1'b0, 64'h40,    8'd1, 2'b00, 4'd7,  64'h0,    1'b0, ALL,         2'b00, 0};
    vecs[7]  = '{1'b1, 64'd3968,  8'd3, 2'b01, 4'd8,  64'h100,  1'b0, ALL,         2'b10, 0};
    vecs[8]  = '{1'b0, 64'd3968,  8'd3, 2'b01, 4'd9,  64'h0,    1'b0, ALL,         2'b00, 0};
    vecs[9]  = '{1'b1, 64'h200,   8'd1, 2'b11, 4'd10, 64'h55,   1'b0, ALL,         2'b00, 0};
    vecs[10] = '{1'b0, 64'h200,   8'd0, 2'b10, 4'd11, 64'h0,    1'b0, ALL,         2'b00, 0};
    vecs[11] = '{1'b0, 64'd5000,  8'd0, 2'b01, 4'd12, 64'h0,    1'b0, ALL,         2'b00, 0};
    vecs[12] = '{1'b0, 64'h7F,    8'd0, 2'b01, 4'd13, 64'h0,    1'b0, ALL,         2'b00, 0};

    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_awready", DW'(s_axi.awready), DW'(1'b0));
    check("rst_arready", DW'(s_axi.arready), DW'(1'b0));
    check("rst_wready",  DW'(s_axi.wready),  DW'(1'b0));
    check("rst_bvalid",  DW'(s_axi.bvalid),  DW'(1'b0));
    check("rst_rvalid",  DW'(s_axi.rvalid),  DW'(1'b0));
    check("rst_rlast",   DW'(s_axi.rlast),   DW'(1'b0));
    check("rst_bresp",   DW'(s_axi.bresp),   DW'(2'b00));
    check("rst_rresp",   DW'(s_axi.rresp),   DW'(2'b00));
    resetn = 1'b1;
    #1;
    check("post_rst_awready", DW'(s_axi.awready), DW'(1'b1));
    check("post_rst_arready", DW'(s_axi.arready), DW'(1'b1));

    // W beat offered before any AW must be refused
    @(negedge clk);
    s_axi.wdata = '1; s_axi.wstrb = ALL; s_axi.wlast = 1'b1; s_axi.wvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("early_w_refused", DW'(s_axi.wready), DW'(1'b0));
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else            do_read(vecs[i]);
    end

    // Concurrent bursts to disjoint words, then reset while the read is mid-burst
    v = '{1'b1, 64'd640, 8'd7, 2'b01, 4'd1, 64'h700, 1'b0, ALL, 2'b00, 0};
    do_write(v);
    @(negedge clk);
    s_axi.awaddr = 64'd1280; s_axi.awlen = 8'd3; s_axi.awburst = 2'b01; s_axi.awid = 4'd3;
    s_axi.araddr = 64'd640;  s_axi.arlen = 8'd7; s_axi.arburst = 2'b01; s_axi.arid = 4'd2;
    s_axi.awvalid = 1'b1; s_axi.arvalid = 1'b1;
    check("conc_awready", DW'(s_axi.awready), DW'(1'b1));
    check("conc_arready", DW'(s_axi.arready), DW'(1'b1));
    @(posedge clk); #1 s_axi.awvalid = 1'b0; s_axi.arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      s_axi.wdata = DW'(64'h2000 + 64'(b)); s_axi.wstrb = ALL; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b1;
      check("conc_wready", DW'(s_axi.wready), DW'(1'b1));
      @(posedge clk);
      model_write(64'd1280 + 64'(b * BPW), DW'(64'h2000 + 64'(b)), ALL);
      #1 s_axi.wvalid = 1'b0;
    end
    @(negedge clk);
    check("conc_rvalid", DW'(s_axi.rvalid), DW'(1'b1));
    check("conc_rdata", s_axi.rdata, model[10]);
    #2 resetn = 1'b0;
    #1;
    check("midrst_awready", DW'(s_axi.awready), DW'(1'b0));
    check("midrst_arready", DW'(s_axi.arready), DW'(1'b0));
    check("midrst_wready",  DW'(s_axi.wready),  DW'(1'b0));
    check("midrst_bvalid",  DW'(s_axi.bvalid),  DW'(1'b0));
    check("midrst_rvalid",  DW'(s_axi.rvalid),  DW'(1'b0));
    check("midrst_rlast",   DW'(s_axi.rlast),   DW'(1'b0));
    @(negedge clk);
    check("midrst_rvalid_held", DW'(s_axi.rvalid), DW'(1'b0));
    idle_inputs();
    resetn = 1'b1;
    #1;
    check("release_arready", DW'(s_axi.arready), DW'(1'b1));
    check("release_awready", DW'(s_axi.awready), DW'(1'b1));
    check("release_wready",  DW'(s_axi.wready),  DW'(1'b0));

    // Words written before the reset keep their data
    v = '{1'b0, 64'd1280, 8'd1, 2'b01, 4'd4, 64'h0, 1'b0, ALL, 2'b00, 0};
    do_read(v);
    v = '{1'b0, 64'd640, 8'd0, 2'b01, 4'd14, 64'h0, 1'b0, ALL, 2'b00, 0};
    do_read(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog");
  end
endmodule
